// File: rtl/bip_pkg.sv
// Shared definitions for the BIP program loader.
//   - Default geometry of the BIP instruction / program memory.
//   - HLT opcode, loader state encoding, error codes.
//   - BYTES_PER_WORD and a helper to derive it for other geometries.
// Optional feature macro: BIP_LOADER_CHECKSUM_EN (adds the CHECK state).
package bip_pkg;

  localparam int NB_INSTRUCTION_DEF = 16;
  localparam int NB_ADDR_DEF        = 11;
  localparam int NB_OPCODE_DEF      = 5;
  localparam int NB_BYTE_DEF        = 8;

  localparam logic [4:0] OPC_HLT = 5'b00000;

  localparam int BYTES_PER_WORD = NB_INSTRUCTION_DEF / NB_BYTE_DEF;

  function automatic int bytes_per_word(input int nb_instr, input int nb_byte);
    return nb_instr / nb_byte;
  endfunction

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
`ifdef BIP_LOADER_CHECKSUM_EN
    CHECK = 3'd3,
`endif
    DONE  = 3'd4,
    ERROR = 3'd5
  } loader_state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_OVERFLOW = 2'b01;
  localparam logic [1:0] ERR_CHECKSUM = 2'b10;

endpackage

// File: rtl/bip_program_loader_if.sv
// Byte-stream input and program-memory write port of the loader.
//   rx_data/rx_valid/rx_ready : byte stream, transfer on valid && ready
//   mem_wr_enable/addr/data   : one-cycle write strobe per packed word
// master = loader side, slave = environment (UART RX + program memory).
interface bip_program_loader_if #(
  parameter int NB_INSTRUCTION = 16,
  parameter int NB_ADDR        = 11,
  parameter int NB_BYTE        = 8
);
  logic [NB_BYTE-1:0]        rx_data;
  logic                      rx_valid;
  logic                      rx_ready;
  logic                      mem_wr_enable;
  logic [NB_ADDR-1:0]        mem_addr;
  logic [NB_INSTRUCTION-1:0] mem_data;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, mem_wr_enable, mem_addr, mem_data
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, mem_wr_enable, mem_addr, mem_data
  );
endinterface

// File: rtl/bip_loader_word_packer.sv
// Packs a byte stream little-endian into NB_INSTRUCTION-bit words.
//   i_clock, i_reset : clock, synchronous active-high reset
//   i_clear          : restart packing at lane 0 (new load)
//   i_byte_valid     : i_byte is accepted this cycle
//   i_byte           : incoming byte
//   o_word           : packed word (complete the cycle after o_word_done)
//   o_word_done      : the byte accepted this cycle fills the last lane
module bip_loader_word_packer
  import bip_pkg::*;
#(
  parameter int NB_INSTRUCTION = 16,
  parameter int NB_BYTE        = 8
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_clear,
  input  logic                      i_byte_valid,
  input  logic [NB_BYTE-1:0]        i_byte,
  output logic [NB_INSTRUCTION-1:0] o_word,
  output logic                      o_word_done
);
  localparam int BPW   = bytes_per_word(NB_INSTRUCTION, NB_BYTE);
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

  logic [IDX_W-1:0]          r_idx;
  logic [NB_INSTRUCTION-1:0] r_word;
  logic                      w_last;

  assign w_last      = (r_idx == LAST_IDX);
  assign o_word_done = i_byte_valid && w_last;
  assign o_word      = r_word;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_byte_valid) begin
      // first byte of a word lands in the LSB lane
      for (int i = 0; i < BPW; i++)
        if (r_idx == IDX_W'(i)) r_word[i*NB_BYTE +: NB_BYTE] <= i_byte;
      r_idx <= w_last ? '0 : r_idx + 1'b1;
    end
  end
endmodule

// File: rtl/bip_program_loader.sv
// BIP program loader: fills program memory from a UART byte stream and
// holds the CPU in reset until a HLT word has been stored.
//   i_clock, i_reset : sole clock, synchronous active-high reset
//   i_start          : one-cycle pulse, starts (or restarts) a load at addr 0
//   bus (master)     : rx byte stream in, program-memory write port out
//   o_cpu_reset      : high in every state except DONE
//   o_done           : program loaded, CPU released
//   o_error          : 00 none, 01 address overflow, 10 checksum
//   o_word_count     : words written in the current load (HLT included)
// Optional macro BIP_LOADER_CHECKSUM_EN: after the HLT write, one extra byte
// is accepted and compared against the XOR of every program byte.
module bip_program_loader
  import bip_pkg::*;
#(
  parameter int NB_INSTRUCTION = 16,
  parameter int NB_ADDR        = 11,
  parameter int NB_OPCODE      = 5,
  parameter int NB_BYTE        = 8
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  bip_program_loader_if.master bus,
  output logic                 o_cpu_reset,
  output logic                 o_done,
  output logic [1:0]           o_error,
  output logic [NB_ADDR:0]     o_word_count
);
  localparam logic [NB_OPCODE-1:0] W_OPC_HLT = NB_OPCODE'(OPC_HLT);

  loader_state_t             r_state, w_next;
  logic [NB_ADDR-1:0]        r_addr;
  logic [NB_ADDR:0]          r_count;
  logic [1:0]                r_error;

  logic                      w_rx_ready;
  logic                      w_wr_en;
  logic                      w_start_load;
  logic                      w_addr_inc;
  logic                      w_count_inc;
  logic                      w_err_set;
  logic [1:0]                w_err_code;
  logic                      w_load_fire;
  logic                      w_word_done;
  logic [NB_INSTRUCTION-1:0] w_word;
  logic                      w_is_hlt;
  logic                      w_addr_max;

  // Decoded from state rather than rx_ready to keep the ready path
  // free of combinational feedback.
  assign w_load_fire = bus.rx_valid && (r_state == LOAD);
  assign w_is_hlt    = (w_word[NB_INSTRUCTION-1 -: NB_OPCODE] == W_OPC_HLT);
  assign w_addr_max  = (r_addr == {NB_ADDR{1'b1}});

  bip_loader_word_packer #(
    .NB_INSTRUCTION (NB_INSTRUCTION),
    .NB_BYTE        (NB_BYTE)
  ) u_packer (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_clear      (w_start_load),
    .i_byte_valid (w_load_fire),
    .i_byte       (bus.rx_data),
    .o_word       (w_word),
    .o_word_done  (w_word_done)
  );

`ifdef BIP_LOADER_CHECKSUM_EN
  logic [NB_BYTE-1:0] r_xor;
  logic               w_csum_ok;
  assign w_csum_ok = (bus.rx_data == r_xor);
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_rx_ready   = 1'b0;
    w_wr_en      = 1'b0;
    w_start_load = 1'b0;
    w_addr_inc   = 1'b0;
    w_count_inc  = 1'b0;
    w_err_set    = 1'b0;
    w_err_code   = ERR_NONE;
    case (r_state)
      IDLE, DONE, ERROR: begin
        if (i_start) begin
          w_start_load = 1'b1;
          w_next       = LOAD;
        end
      end
      LOAD: begin
        w_rx_ready = 1'b1;
        if (w_word_done) w_next = WRITE;
      end
      WRITE: begin
        w_wr_en     = 1'b1;
        w_count_inc = 1'b1;
        if (w_is_hlt) begin
`ifdef BIP_LOADER_CHECKSUM_EN
          w_next = CHECK;
`else
          w_next = DONE;
`endif
        end else if (w_addr_max) begin
          w_err_set  = 1'b1;
          w_err_code = ERR_OVERFLOW;
          w_next     = ERROR;
        end else begin
          w_addr_inc = 1'b1;
          w_next     = LOAD;
        end
      end
`ifdef BIP_LOADER_CHECKSUM_EN
      CHECK: begin
        w_rx_ready = 1'b1;
        if (bus.rx_valid) begin
          if (w_csum_ok) begin
            w_next = DONE;
          end else begin
            w_err_set  = 1'b1;
            w_err_code = ERR_CHECKSUM;
            w_next     = ERROR;
          end
        end
      end
`endif
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_addr  <= '0;
      r_count <= '0;
      r_error <= ERR_NONE;
    end else if (w_start_load) begin
      r_addr  <= '0;
      r_count <= '0;
      r_error <= ERR_NONE;
    end else begin
      if (w_addr_inc)  r_addr  <= r_addr + 1'b1;
      if (w_count_inc) r_count <= r_count + 1'b1;
      if (w_err_set)   r_error <= w_err_code;
    end
  end

`ifdef BIP_LOADER_CHECKSUM_EN
  // Running XOR of program bytes only; the checksum byte itself is excluded.
  always_ff @(posedge i_clock) begin
    if (i_reset || w_start_load) r_xor <= '0;
    else if (w_load_fire)        r_xor <= r_xor ^ bus.rx_data;
  end
`endif

  assign bus.rx_ready      = w_rx_ready;
  assign bus.mem_wr_enable = w_wr_en;
  assign bus.mem_addr      = r_addr;
  assign bus.mem_data      = w_word;
  assign o_cpu_reset       = (r_state != DONE);
  assign o_done            = (r_state == DONE);
  assign o_error           = r_error;
  assign o_word_count      = r_count;
endmodule
